s9io_work_tx: RTL
=================

Name: s9io_work_tx

Overview:
- Work-transmit framer of the s9io core; sits between the Work Transmit FIFO (fed by AXI writes to WORK_TX_FIFO, 0x0C) and the work UART transmitter.
- Pulls one complete work (job ID word + 3 header words + 8 words per midstate) from the FIFO and serializes it as an ASIC work frame with appended CRC16.
- Enforces the WORK_TIME spacing between frame starts and publishes the LAST_JOB_ID value.

Parameters:
- WT_W, 24, width of work-time counter and work_time input (clock cycles).
- FIFO_CNT_W, 11, width of FIFO occupancy input (words).

Ports:
- clk  in  1  core clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- ctrl_enable  in  1  CTRL_REG enable bit.
- ctrl_midstate  in  2  log2 midstates per work: 0→1, 1→2, 2→4; 3 treated as 4.
- work_time  in  WT_W  minimum cycles between consecutive frame starts.
- fifo_data  in  32  FIFO head word, first-word-fall-through.
- fifo_count  in  FIFO_CNT_W  words present in FIFO.
- fifo_rd  out  1  pop strobe; one word per pulse.
- tx_data  out  8  byte to UART.
- tx_valid  out  1  byte valid.
- tx_ready  in  1  UART accepts byte when tx_valid&tx_ready.
- last_job_id  out  8  job ID of last fully sent frame.
- busy  out  1  frame in progress.

Behaviour:
- Reset: fifo_rd=0, tx_valid=0, tx_data=0, last_job_id=0, busy=0, FSM=IDLE, work-time counter saturated (next frame may start immediately).
- Work size W = 4+8N words, N = 1/2/4; frame length L = 18+32N bytes (50/82/146).
- Start condition in IDLE: ctrl_enable=1 AND fifo_count>=W AND wt_cnt>=work_time. N is latched at start; ctrl_midstate changes apply only to the next frame.
- On start: wt_cnt cleared to 0, then increments every cycle, saturating at all-ones.
- Frame byte order: 0x21, L, job_id[7:0] (word0 bits 7:0; bits 31:8 ignored), N; then words 1..W-1, each sent LSB byte first; then CRC16 high byte, then low byte.
- Word fetch: fifo_rd pulses one cycle when the head word is captured into the shift register; word0 is popped during the header; exactly W pops per frame; no pops in IDLE.
- FSM states:
  - IDLE: wait for the start condition.
  - HDR: 4 bytes.
  - DATA: 4 bytes per word, W-1 words.
  - CRC: 2 bytes.
  - DONE: one cycle; updates last_job_id, then returns to IDLE.
- Handshake: tx_data is stable while tx_valid=1 and tx_ready=0; the next byte is presented the cycle after acceptance or earlier (back-to-back allowed). tx_valid never drops before acceptance.
- CRC16-CCITT: poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR; covers all bytes from 0x21 through the last midstate byte.
- ctrl_enable deasserted mid-frame: current frame completes; no new start. Frames are never truncated.
- busy=1 from the start cycle through DONE.
- FIFO underrun cannot occur, because the full work is gated by fifo_count. If fifo_count drops below the remaining words mid-frame (external FIFO reset), the block behaves as undefined; software must disable before issuing a FIFO reset.
- Latency: start condition true → first byte valid at tx_data on the next cycle.

Test Plan:
- N=1, work_time=0, words {0x0000_0055, 0x1A2B3C4D, 0x5E6F7081, 0x92A3B4C5, 8 midstate words}, tx_ready=1 → 50 bytes: 21 32 55 01 4D 3C 2B 1A 81 ...; CRC matches model; exactly 12 fifo_rd pulses; last_job_id=0x55 after DONE.
- N=4, fifo_count=35 (<36) → no fifo_rd, tx_valid stays 0; raise to 36 → 146-byte frame, length byte 0x92, midstate byte 0x04.
- work_time=2000, three queued N=2 works → frame starts spaced exactly 2000 cycles apart (frame duration < 2000); length byte 0x52.
- tx_ready randomly stalled (30% duty) → byte sequence identical to the unstalled case; tx_data stable during stalls.
- ctrl_enable cleared at byte 20 of an N=1 frame → all 50 bytes are sent; next queued work is not started until enable=1.
- rst_n asserted mid-frame → outputs return to reset values asynchronously; after release with work present and work_time=0, a new frame starts immediately.

Source files
------------

// File: rtl/s9io_work_tx.sv
// s9io work-transmit framer: pulls one complete work from the work FIFO and
// sends it to the UART as an ASIC work frame with a trailing CRC16.
module s9io_work_tx #(
   parameter int WT_W       = 24,
   parameter int FIFO_CNT_W = 11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ctrl_enable,
   input  logic [1:0]            ctrl_midstate,
   input  logic [WT_W-1:0]       work_time,
   input  logic [31:0]           fifo_data,
   input  logic [FIFO_CNT_W-1:0] fifo_count,
   output logic                  fifo_rd,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [7:0]            last_job_id,
   output logic                  busy
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_DATA = 3'd2,
      ST_CRC  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
      logic [15:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   state_t          r_state;
   logic [1:0]      r_m;
   logic [7:0]      r_len;
   logic [5:0]      r_last_word;
   logic [5:0]      r_word;
   logic [1:0]      r_idx;
   logic [31:0]     r_shift;
   logic [15:0]     r_crc;
   logic [7:0]      r_job_id;
   logic [WT_W-1:0] r_wt_cnt;
   logic            r_fifo_rd;
   logic [7:0]      r_tx_data;
   logic            r_tx_valid;
   logic [7:0]      r_last_job_id;
   logic            r_busy;

   logic [1:0]      w_m;
   logic [6:0]      w_words;
   logic [7:0]      w_len;
   logic            w_start;
   logic            w_accept;
   logic [15:0]     w_crc_next;
   logic [7:0]      w_hdr_byte;

   // Frame geometry, start qualification and next-byte selection.
   always_comb begin
      w_m = ctrl_midstate;
      if (ctrl_midstate == 2'd3) w_m = 2'd2;
      else                       w_m = ctrl_midstate;
      w_words    = 7'd4 + (7'd8 << w_m);
      w_len      = 8'd18 + (8'd32 << w_m);
      w_start    = (r_state == ST_IDLE) && ctrl_enable &&
                   (fifo_count >= FIFO_CNT_W'(w_words)) && (r_wt_cnt >= work_time);
      w_accept   = r_tx_valid && tx_ready;
      w_crc_next = crc16_byte(r_crc, r_tx_data);
      case (r_idx)
         2'd0:    w_hdr_byte = r_len;
         2'd1:    w_hdr_byte = r_job_id;
         2'd2:    w_hdr_byte = 8'd1 << r_m;
         default: w_hdr_byte = 8'h00;
      endcase
   end

   // Work-time counter; it reads 0 during the start cycle, so it loads 1 for the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_wt_cnt <= {WT_W{1'b1}};
      else if (w_start)                    r_wt_cnt <= WT_W'(1);
      else if (r_wt_cnt != {WT_W{1'b1}})   r_wt_cnt <= r_wt_cnt + WT_W'(1);
      else                                 r_wt_cnt <= r_wt_cnt;
   end

   // Framing FSM: header, data words, CRC, then publish the job ID.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_m           <= 2'd0;
         r_len         <= 8'h00;
         r_last_word   <= 6'd0;
         r_word        <= 6'd0;
         r_idx         <= 2'd0;
         r_shift       <= 32'h0000_0000;
         r_crc         <= 16'hFFFF;
         r_job_id      <= 8'h00;
         r_fifo_rd     <= 1'b0;
         r_tx_data     <= 8'h00;
         r_tx_valid    <= 1'b0;
         r_last_job_id <= 8'h00;
         r_busy        <= 1'b0;
      end else begin
         r_fifo_rd <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state     <= ST_HDR;
                  r_m         <= w_m;
                  r_len       <= w_len;
                  r_last_word <= 6'(w_words - 7'd1);
                  r_job_id    <= fifo_data[7:0];
                  r_fifo_rd   <= 1'b1;
                  r_tx_data   <= 8'h21;
                  r_tx_valid  <= 1'b1;
                  r_busy      <= 1'b1;
                  r_crc       <= 16'hFFFF;
                  r_idx       <= 2'd0;
               end
            end
            ST_HDR: begin
               if (w_accept) begin
                  r_crc <= w_crc_next;
                  if (r_idx == 2'd3) begin
                     r_state   <= ST_DATA;
                     r_shift   <= fifo_data;
                     r_tx_data <= fifo_data[7:0];
                     r_fifo_rd <= 1'b1;
                     r_word    <= 6'd1;
                     r_idx     <= 2'd0;
                  end else begin
                     r_tx_data <= w_hdr_byte;
                     r_idx     <= r_idx + 2'd1;
                  end
               end
            end
            ST_DATA: begin
               if (w_accept) begin
                  r_crc <= w_crc_next;
                  if (r_idx != 2'd3) begin
                     r_tx_data <= r_shift[15:8];
                     r_shift   <= {8'h00, r_shift[31:8]};
                     r_idx     <= r_idx + 2'd1;
                  end else if (r_word == r_last_word) begin
                     r_state   <= ST_CRC;
                     r_tx_data <= w_crc_next[15:8];
                     r_idx     <= 2'd0;
                  end else begin
                     r_shift   <= fifo_data;
                     r_tx_data <= fifo_data[7:0];
                     r_fifo_rd <= 1'b1;
                     r_word    <= r_word + 6'd1;
                     r_idx     <= 2'd0;
                  end
               end
            end
            ST_CRC: begin
               if (w_accept) begin
                  if (r_idx == 2'd0) begin
                     r_tx_data <= r_crc[7:0];
                     r_idx     <= 2'd1;
                  end else begin
                     r_tx_data  <= 8'h00;
                     r_tx_valid <= 1'b0;
                     r_state    <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_last_job_id <= r_job_id;
               r_busy        <= 1'b0;
               r_state       <= ST_IDLE;
            end
            default: begin
               r_tx_valid <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign fifo_rd     = r_fifo_rd;
   assign tx_data     = r_tx_data;
   assign tx_valid    = r_tx_valid;
   assign last_job_id = r_last_job_id;
   assign busy        = r_busy;

endmodule
